// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with a valid/ready load side, a one-word
// hold buffer so frames stream back-to-back, and a serial-side stall (S_EN).
// Outputs are registered. P_READY only reflects whether the hold buffer is empty.
module piso_serializer #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] P_IN,
    input  logic             P_VALID,
    output logic             P_READY,
    input  logic             S_EN,
    output logic             S_OUT,
    output logic             S_VALID,
    output logic             S_LAST
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic [CW-1:0]    cnt;

    logic accept;
    logic consume;
    logic last_consume;

    // Handshake qualifiers; P_READY has no bypass around a full hold buffer.
    always_comb begin
        P_READY      = ~hold_full;
        accept       = P_VALID & ~hold_full;
        consume      = S_VALID & S_EN;
        last_consume = consume & (cnt == LAST_IDX);
    end

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Frame FSM: loads words (directly or from hold), shifts on consume, registers outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            shreg     <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            S_OUT     <= 1'b0;
            S_VALID   <= 1'b0;
            S_LAST    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        shreg   <= P_IN;
                        cnt     <= '0;
                        S_OUT   <= first_bit(P_IN);
                        S_VALID <= 1'b1;
                        S_LAST  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_consume) begin
                        if (hold_full) begin
                            // Zero-gap handoff: the buffered word becomes the next frame.
                            shreg     <= hold_q;
                            hold_full <= 1'b0;
                            cnt       <= '0;
                            S_OUT     <= first_bit(hold_q);
                            S_LAST    <= 1'b0;
                        end else if (accept) begin
                            shreg  <= P_IN;
                            cnt    <= '0;
                            S_OUT  <= first_bit(P_IN);
                            S_LAST <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            cnt     <= '0;
                            S_OUT   <= 1'b0;
                            S_VALID <= 1'b0;
                            S_LAST  <= 1'b0;
                        end
                    end else begin
                        if (consume) begin
                            shreg  <= shifted(shreg);
                            cnt    <= cnt + CW'(1);
                            S_OUT  <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
                            S_LAST <= ((cnt + CW'(1)) == LAST_IDX);
                        end
                        if (accept) begin
                            hold_q    <= P_IN;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
